uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte FIFO between the ramio UART-out write path and uarttx, so firmware can queue several bytes without polling the transmitter after each one.
- Upstream side is a single-cycle write strobe from ramio. Downstream side drives uarttx with the go / busy handshake that ramio uses directly today.
- ramio reads `full` and `count` through the UART-out status word.

Parameters:
- DepthBitWidth, 4, log2 of FIFO depth. Depth = 2^DepthBitWidth entries of 8 bits (16 by default).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  push wr_data this cycle
- wr_data  input  8  byte to enqueue
- full  output  1  count == 2^DepthBitWidth
- empty  output  1  count == 0
- count  output  DepthBitWidth+1  entries currently stored, excluding the byte in flight
- overflow  output  1  sticky; set when wr_en arrives while full
- clr_overflow  input  1  clears overflow
- ut_go  output  1  to uarttx go: request transmission of ut_data
- ut_data  output  8  byte presented to uarttx, held stable while ut_go=1
- ut_busy  input  1  from uarttx busy
- idle  output  1  empty && state==IDLE; all queued bytes fully sent

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, full=0, empty=1, overflow=0, ut_go=0, ut_data=0, state=IDLE, idle=1. Reset wins over every other input in the same cycle; an in-flight byte is abandoned and ut_go drops the next cycle.
- Storage: 2^DepthBitWidth x 8 register array. Pointers are DepthBitWidth bits and wrap naturally modulo depth. count is a separate DepthBitWidth+1 bit counter.
- Outputs full, empty, count and idle are registered-state derived (combinational from registers), with no dependence on same-cycle inputs.
- Push: wr_en && !full writes mem[wr_ptr], then wr_ptr++.
- Push while full: the byte is dropped, pointers are unchanged, and overflow is set at the next edge.
- overflow: clr_overflow clears it. If a set and a clear happen in the same cycle, set wins.
- Pop: happens only on the IDLE->SEND transition. ut_data <= mem[rd_ptr], then rd_ptr++.
- Simultaneous push and pop: count unchanged, and both pointers advance.
- Push while full in the same cycle as a pop: still dropped, because full is evaluated on the pre-edge state.
- Write latency: a byte pushed at edge N can be popped at edge N+1 at the earliest (no write-through). ut_go first rises at edge N+1.
- Downstream FSM (one state per step):
  - IDLE: if !empty, pop, set ut_go=1, go to SEND. Otherwise stay in IDLE.
  - SEND: hold ut_go=1 and ut_data. When ut_busy==1, go to WAIT_DONE.
  - WAIT_DONE: hold ut_go=1. When ut_busy==0, set ut_go=0 and go to ACK.
  - ACK: ut_go=0 for exactly one cycle, then go to IDLE. This gives uarttx its go-low acknowledge.
- Throughput: back-to-back bytes are separated by a minimum of 2 cycles of ut_go=0 (ACK, then the IDLE pop cycle).
- ut_data changes only on the IDLE->SEND edge.
- Pre-existing ut_busy: if ut_busy is already 1 on entry to SEND, the FSM moves to WAIT_DONE on the next edge. No byte is lost.
- Sizing: no combinational path from wr_en to ut_go. Target 120-250 lines of RTL.

Test Plan:
1. Reset, then push 0xAA; uarttx model asserts busy 2 cycles after go and holds it 20 cycles.
   -> ut_go rises 1 cycle after the push with ut_data=0xAA; count returns to 0.
   -> ut_go falls the cycle after busy falls; idle=1 after the ACK cycle.
2. Push 0x01..0x10 in 16 consecutive cycles with busy stuck at 1.
   -> count peaks at 15, because 0x01 was popped in the cycle after its push.
   -> A 17th push of 0x11 sets full=1. An 18th push of 0x22 sets overflow=1 and count stays 16.
   -> After releasing busy, bytes emerge in order 0x01..0x11 with 0x22 absent.
3. With count=3, assert wr_en in the IDLE pop cycle -> count stays 3, and wr_ptr and rd_ptr both increment.
4. Pointer wrap: push and drain 20 bytes with a depth-4 instance (DepthBitWidth=2).
   -> Order is preserved across the wrap; empty=1 and count=0 at the end.
5. Assert rst while in WAIT_DONE with count=5 -> next cycle ut_go=0, count=0, empty=1, overflow=0, state IDLE.
6. Raise overflow, then assert clr_overflow together with a push while full -> overflow remains 1. A lone clr_overflow the next cycle -> overflow=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the ramio UART-out write strobe and the uarttx go/busy handshake.
// Latency: a byte pushed at edge N is popped onto ut_go/ut_data at edge N+1 at the earliest.
// Backpressure: the writer is never stalled; a push while full is dropped and latched in sticky overflow.
module uart_tx_fifo #(
  parameter int DepthBitWidth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [DepthBitWidth:0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     ut_go,
  output logic [7:0]               ut_data,
  input  logic                     ut_busy,
  output logic                     idle
);

  localparam int Depth = 1 << DepthBitWidth;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, ACK} state_e;

  logic [7:0]               mem_q [Depth];
  logic [DepthBitWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthBitWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [DepthBitWidth:0]   count_q, count_d;
  logic                     overflow_q, overflow_d;
  state_e                   state_q;
  logic                     ut_go_q;
  logic [7:0]               ut_data_q;
  logic                     push;
  logic                     pop;

  // Status is derived from registered state only, never from same-cycle inputs.
  assign empty    = (count_q == '0);
  // count never exceeds Depth, so its top bit alone means "exactly Depth entries".
  assign full     = count_q[DepthBitWidth];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign ut_go    = ut_go_q;
  assign ut_data  = ut_data_q;
  assign idle     = empty && (state_q == IDLE);

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    push       = wr_en && !full;
    pop        = (state_q == IDLE) && !empty;
    wr_ptr_d   = push ? wr_ptr_q + DepthBitWidth'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + DepthBitWidth'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DepthBitWidth+1)'(1);
      2'b01:   count_d = count_q - (DepthBitWidth+1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    // A dropped push in the same cycle as a clear still leaves the flag set.
    if (wr_en && full) overflow_d = 1'b1;
  end

  // Storage array; no reset needed since empty slots are never read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer, occupancy and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Downstream handshake FSM: go stays high until busy has been seen and released, then one go-low ACK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ut_go_q   <= 1'b0;
      ut_data_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            ut_data_q <= mem_q[rd_ptr_q];
            ut_go_q   <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (ut_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!ut_busy) begin
            ut_go_q <= 1'b0;
            state_q <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          ut_go_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a scoreboard of expected transmitted bytes.
// Latency: bytes are checked as ut_go rises, in push order.
// Backpressure: a small uarttx model drives busy, or the sequence drives it directly.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en, clr_overflow, ut_busy;
  logic [7:0] wr_data;
  logic       full, empty, overflow, ut_go, idle;
  logic [4:0] count;
  logic [7:0] ut_data;

  logic       wr_en4, busy4;
  logic [7:0] wr_data4;
  logic       full4, empty4, overflow4, go4, idle4;
  logic [2:0] count4;
  logic [7:0] data4;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];

  bit busy_manual = 1'b0;
  int busy_len    = 20;

  uart_tx_fifo #(.DepthBitWidth(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .clr_overflow(clr_overflow), .ut_go(ut_go),
    .ut_data(ut_data), .ut_busy(ut_busy), .idle(idle)
  );

  uart_tx_fifo #(.DepthBitWidth(2)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_data(wr_data4), .full(full4), .empty(empty4),
    .count(count4), .overflow(overflow4), .clr_overflow(1'b0), .ut_go(go4),
    .ut_data(data4), .ut_busy(busy4), .idle(idle4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] d, input bit acc);
    wr_en   = we;
    wr_data = d;
    if (we && acc) exp_q.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic drive4(input logic [7:0] d);
    wr_en4   = 1'b1;
    wr_data4 = d;
    exp4_q.push_back(d);
    @(posedge clk); #1;
    wr_en4 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!idle && k < 800) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, idle}, 32'd1);
  endtask

  // uarttx model: busy rises two cycles after go, holds busy_len cycles, then waits for go low.
  initial begin
    ut_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (busy_manual) begin
      end else if (ut_go) begin
        @(posedge clk); #1;
        ut_busy = 1'b1;
        repeat (busy_len) begin @(posedge clk); #1; end
        ut_busy = 1'b0;
        for (int k = 0; k < 8 && ut_go; k++) begin @(posedge clk); #1; end
      end else begin
        ut_busy = 1'b0;
      end
    end
  end

  // uarttx model for the depth-4 instance: short fixed busy pulse.
  initial begin
    busy4 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (go4) begin
        busy4 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        busy4 = 1'b0;
        for (int k = 0; k < 8 && go4; k++) begin @(posedge clk); #1; end
      end
    end
  end

  // Scoreboard monitor for the main instance.
  logic       go_prev = 1'b0;
  logic [7:0] data_hold = 8'h00;
  always @(negedge clk) begin
    if (ut_go === 1'b1 && go_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", {24'd0, ut_data}, 32'hFFFF_FFFF);
      end else begin
        check("sb_byte", {24'd0, ut_data}, {24'd0, exp_q.pop_front()});
      end
      data_hold = ut_data;
    end else if (ut_go === 1'b1) begin
      check("sb_data_stable", {24'd0, ut_data}, {24'd0, data_hold});
    end
    go_prev = ut_go;
  end

  // Scoreboard monitor for the depth-4 instance.
  logic go4_prev = 1'b0;
  always @(negedge clk) begin
    if (go4 === 1'b1 && go4_prev !== 1'b1) begin
      if (exp4_q.size() == 0) begin
        check("sb4_unexpected_byte", {24'd0, data4}, 32'hFFFF_FFFF);
      end else begin
        check("sb4_byte", {24'd0, data4}, {24'd0, exp4_q.pop_front()});
      end
    end
    go4_prev = go4;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
    wr_en4 = 1'b0; wr_data4 = 8'h00;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    check("rst_ut_go", ut_go, 0);
    check("rst_ut_data", ut_data, 0);
    check("rst_idle", idle, 1);

    // Test 1: single byte, 20-cycle busy
    drive(1'b1, 8'hAA, 1'b1);
    @(negedge clk);
    check("t1_count_after_push", count, 1);
    check("t1_no_write_through", ut_go, 0);
    @(negedge clk);
    check("t1_go_rises", ut_go, 1);
    check("t1_ut_data", ut_data, 8'hAA);
    check("t1_count_zero", count, 0);
    k = 0;
    while (ut_busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("t1_busy_seen", ut_busy, 1);
    k = 0;
    while (ut_busy !== 1'b0 && k < 40) begin @(negedge clk); k++; end
    check("t1_busy_released", ut_busy, 0);
    check("t1_go_held", ut_go, 1);
    @(negedge clk);
    check("t1_go_falls", ut_go, 0);
    check("t1_ack_not_idle", idle, 0);
    @(negedge clk);
    check("t1_idle", idle, 1);
    busy_len = 3;

    // Test 2 and 6: fill with busy stuck, overflow, set-wins clear
    busy_manual = 1'b1;
    ut_busy = 1'b1;
    for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1);
    @(negedge clk);
    check("t2_count_peak", count, 15);
    check("t2_not_full", full, 0);
    drive(1'b1, 8'h11, 1'b1);
    @(negedge clk);
    check("t2_count_16", count, 16);
    check("t2_full", full, 1);
    check("t2_no_overflow_yet", overflow, 0);
    drive(1'b1, 8'h22, 1'b0);
    @(negedge clk);
    check("t2_overflow_set", overflow, 1);
    check("t2_count_stays", count, 16);
    clr_overflow = 1'b1;
    drive(1'b1, 8'h33, 1'b0);
    clr_overflow = 1'b0;
    @(negedge clk);
    check("t6_set_wins", overflow, 1);
    check("t6_count_stays", count, 16);
    clr_overflow = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    clr_overflow = 1'b0;
    @(negedge clk);
    check("t6_clear", overflow, 0);
    busy_manual = 1'b0;
    wait_idle("t2_drain_idle");
    check("t2_all_bytes_out", exp_q.size(), 0);
    check("t2_count_end", count, 0);

    // Test 3: push during the IDLE pop cycle with count=3
    busy_manual = 1'b1;
    ut_busy = 1'b1;
    drive(1'b1, 8'h31, 1'b1);
    drive(1'b1, 8'h32, 1'b1);
    drive(1'b1, 8'h33, 1'b1);
    drive(1'b1, 8'h34, 1'b1);
    @(negedge clk);
    check("t3_count_3", count, 3);
    ut_busy = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_pre_go_low", ut_go, 0);
    check("t3_pre_count", count, 3);
    drive(1'b1, 8'h35, 1'b1);
    @(negedge clk);
    check("t3_count_unchanged", count, 3);
    check("t3_go", ut_go, 1);
    check("t3_data", ut_data, 8'h32);
    busy_manual = 1'b0;
    wait_idle("t3_drain_idle");
    check("t3_all_bytes_out", exp_q.size(), 0);

    // Test 5: reset while in WAIT_DONE with count=5
    busy_manual = 1'b1;
    ut_busy = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h51 + 8'(i), i == 0);
    @(negedge clk);
    check("t5_count_5", count, 5);
    check("t5_go_high", ut_go, 1);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_go_low", ut_go, 0);
    check("t5_count", count, 0);
    check("t5_empty", empty, 1);
    check("t5_overflow", overflow, 0);
    check("t5_idle", idle, 1);
    ut_busy = 1'b0;
    busy_manual = 1'b0;
    check("t5_queue_consumed", exp_q.size(), 0);

    // Test 4: pointer wrap on the depth-4 instance
    for (int i = 0; i < 20; i++) begin
      k = 0;
      while (full4 && k < 60) begin @(posedge clk); #1; k++; end
      if (k >= 60) check("t4_full_timeout", full4, 0);
      drive4(8'h60 + 8'(i));
    end
    k = 0;
    while (!idle4 && k < 400) begin @(negedge clk); k++; end
    check("t4_idle", idle4, 1);
    check("t4_empty", empty4, 1);
    check("t4_count", count4, 0);
    check("t4_no_overflow", overflow4, 0);
    check("t4_all_bytes_out", exp4_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
